// File: rtl/wishbone_rr_arbiter_pkg.sv
// Shared definitions for the wishbone round-robin arbiter: grant state
// encoding, the supported master count and a generic round-robin pick helper.
package wb_arb_pkg;

  localparam int ARB_MAX_MASTERS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    FAULT = 2'd2
  } arb_state_t;

  // One-hot grant for the first set bit of req searching upward from
  // (last + 1) mod n; all zero when nothing is requested.
  function automatic logic [ARB_MAX_MASTERS-1:0] rr_next(
    input logic [ARB_MAX_MASTERS-1:0] req,
    input logic [2:0]                 last,
    input int unsigned                n
  );
    logic [ARB_MAX_MASTERS-1:0] grant;
    logic [31:0]                idx;
    logic                       found;
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= ARB_MAX_MASTERS; i++) begin
      if (i <= n) begin
        idx = (32'(last) + 32'(i)) % 32'(n);
        if (!found && req[idx[2:0]]) begin
          grant[idx[2:0]] = 1'b1;
          found           = 1'b1;
        end else begin
          found = found;
        end
      end else begin
        found = found;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/wishbone_rr_arbiter_if.sv
// Bus bundle between N wishbone masters, the arbiter and the shared slave.
// The arbiter uses the slave modport; the surrounding fabric uses master.
interface wishbone_rr_arbiter_if #(
  parameter int NUM_MASTERS  = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = 4
);
  logic [NUM_MASTERS-1:0]              m_cyc_i;
  logic [NUM_MASTERS-1:0]              m_stb_i;
  logic [NUM_MASTERS-1:0]              m_we_i;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_adr_i;
  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_dat_i;
  logic [NUM_MASTERS*SELECT_WIDTH-1:0] m_sel_i;
  logic [DATA_WIDTH-1:0]               m_dat_o;
  logic [NUM_MASTERS-1:0]              m_ack_o;
  logic [NUM_MASTERS-1:0]              m_err_o;
  logic [NUM_MASTERS-1:0]              m_rty_o;
  logic                                s_cyc_o;
  logic                                s_stb_o;
  logic                                s_we_o;
  logic [ADDR_WIDTH-1:0]               s_adr_o;
  logic [DATA_WIDTH-1:0]               s_dat_o;
  logic [SELECT_WIDTH-1:0]             s_sel_o;
  logic [DATA_WIDTH-1:0]               s_dat_i;
  logic                                s_ack_i;
  logic                                s_err_i;
  logic                                s_rty_i;
  logic [NUM_MASTERS-1:0]              grant_o;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
    output m_dat_o, m_ack_o, m_err_o, m_rty_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    output grant_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    output s_dat_i, s_ack_i, s_err_i, s_rty_i,
    input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    input  grant_o
  );
endinterface

// File: rtl/wishbone_rr_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: rotate the request vector so the entry
// after 'last' sits at bit 0, take the lowest set bit, rotate back.
module rr_priority_picker #(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last,
  output logic [NUM_MASTERS-1:0] grant
);
  logic [IDX_W-1:0]       start_s;
  logic [NUM_MASTERS-1:0] rot_s;
  logic [NUM_MASTERS-1:0] first_s;
  logic                   found_s;

  // Rotate, isolate the first requester, rotate back into master order.
  always_comb begin
    if (last == IDX_W'(NUM_MASTERS - 1)) begin
      start_s = '0;
    end else begin
      start_s = last + 1'b1;
    end
    rot_s   = NUM_MASTERS'({req, req} >> start_s);
    first_s = '0;
    found_s = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!found_s && rot_s[i]) begin
        first_s[i] = 1'b1;
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    grant = NUM_MASTERS'(({first_s, first_s} << start_s) >> NUM_MASTERS);
  end
endmodule

// File: rtl/wishbone_rr_arbiter.sv
// Round-robin arbiter sharing one wishbone slave among NUM_MASTERS masters.
// A grant is held while the owner keeps cyc high; the slave-side mux is
// combinational from the registered owner. Optional watchdog enabled by
// defining WB_ARB_TIMEOUT_EN (adds the one-cycle FAULT state).
module wishbone_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SELECT_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                    clk_i,
  input logic                    reset_n,
  wishbone_rr_arbiter_if.slave   bus
);
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  arb_state_t             state_r, state_nxt_s;
  logic [NUM_MASTERS-1:0] grant_r, grant_nxt_s, pick_s;
  logic [IDX_W-1:0]       owner_r, owner_nxt_s, last_r, last_nxt_s;
  logic [IDX_W-1:0]       pick_last_s, pick_idx_s;
  logic                   owner_cyc_s, release_s, timeout_hit_s;

  assign owner_cyc_s = bus.m_cyc_i[owner_r];
  assign pick_last_s = (state_r == IDLE) ? last_r : owner_r;
  assign bus.grant_o = grant_r;

  rr_priority_picker #(
    .NUM_MASTERS(NUM_MASTERS),
    .IDX_W      (IDX_W)
  ) u_picker (
    .req  (bus.m_cyc_i),
    .last (pick_last_s),
    .grant(pick_s)
  );

  // Binary index of the picked master, stored alongside the one-hot grant.
  always_comb begin
    pick_idx_s = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pick_s[i]) begin
        pick_idx_s = IDX_W'(i);
      end else begin
        pick_idx_s = pick_idx_s;
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             stall_s;

  assign stall_s       = bus.m_stb_i[owner_r] &
                         ~(bus.s_ack_i | bus.s_err_i | bus.s_rty_i);
  assign timeout_hit_s = (state_r == GRANT) && owner_cyc_s && stall_s &&
                         (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count stalled strobe cycles of the current owner; any termination,
  // release or fault restarts the count.
  always_comb begin
    if ((state_r == GRANT) && owner_cyc_s && stall_s && !timeout_hit_s) begin
      cnt_nxt_s = cnt_r + 1'b1;
    end else begin
      cnt_nxt_s = '0;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end
`else
  logic unused_timeout_s;
  assign timeout_hit_s    = 1'b0;
  assign unused_timeout_s = (TIMEOUT_CYCLES == 0);
`endif

  // Grant FSM next state: idle pick, hold while owner cyc stays high,
  // hand over without an idle cycle on release.
  always_comb begin
    state_nxt_s = state_r;
    grant_nxt_s = grant_r;
    owner_nxt_s = owner_r;
    last_nxt_s  = last_r;
    release_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (|bus.m_cyc_i) begin
          state_nxt_s = GRANT;
          grant_nxt_s = pick_s;
          owner_nxt_s = pick_idx_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT: begin
        if (!owner_cyc_s) begin
          release_s = 1'b1;
        end else if (timeout_hit_s) begin
`ifdef WB_ARB_TIMEOUT_EN
          state_nxt_s = FAULT;
`else
          state_nxt_s = GRANT;
`endif
        end else begin
          state_nxt_s = GRANT;
        end
      end
`ifdef WB_ARB_TIMEOUT_EN
      FAULT: begin
        if (owner_cyc_s) begin
          state_nxt_s = GRANT;
        end else begin
          release_s = 1'b1;
        end
      end
`endif
      default: begin
        state_nxt_s = IDLE;
        grant_nxt_s = '0;
      end
    endcase
    if (release_s) begin
      last_nxt_s = owner_r;
      if (|bus.m_cyc_i) begin
        state_nxt_s = GRANT;
        grant_nxt_s = pick_s;
        owner_nxt_s = pick_idx_s;
      end else begin
        state_nxt_s = IDLE;
        grant_nxt_s = '0;
      end
    end else begin
      last_nxt_s = last_nxt_s;
    end
  end

  // Grant state registers; master 0 has top priority after reset.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      grant_r <= '0;
      owner_r <= '0;
      last_r  <= IDX_W'(NUM_MASTERS - 1);
    end else begin
      state_r <= state_nxt_s;
      grant_r <= grant_nxt_s;
      owner_r <= owner_nxt_s;
      last_r  <= last_nxt_s;
    end
  end

  // Request/response muxing for the current owner; everything quiet otherwise.
  always_comb begin
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_we_o  = 1'b0;
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.s_sel_o = '0;
    bus.m_dat_o = '0;
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    bus.m_rty_o = '0;
    case (state_r)
      GRANT: begin
        bus.s_cyc_o = bus.m_cyc_i[owner_r];
        bus.s_stb_o = bus.m_stb_i[owner_r];
        bus.s_we_o  = bus.m_we_i[owner_r];
        bus.s_adr_o = bus.m_adr_i[owner_r*ADDR_WIDTH +: ADDR_WIDTH];
        bus.s_dat_o = bus.m_dat_i[owner_r*DATA_WIDTH +: DATA_WIDTH];
        bus.s_sel_o = bus.m_sel_i[owner_r*SELECT_WIDTH +: SELECT_WIDTH];
        bus.m_dat_o = bus.s_dat_i;
        bus.m_ack_o = grant_r & {NUM_MASTERS{bus.s_ack_i}};
        bus.m_err_o = grant_r & {NUM_MASTERS{bus.s_err_i}};
        bus.m_rty_o = grant_r & {NUM_MASTERS{bus.s_rty_i}};
      end
`ifdef WB_ARB_TIMEOUT_EN
      FAULT: begin
        bus.m_err_o = grant_r;
      end
`endif
      default: begin
        bus.m_dat_o = '0;
      end
    endcase
  end
endmodule
